// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. Accepts A, B and a carry-in,
// adds one bit per clock LSB-first through a two-half-adder full adder,
// and commits sum, carry-out and signed overflow after WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Counter must hold 0..WIDTH without wrapping inside one operation.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_last;
    logic             w_ha1_s;
    logic             w_ha1_c;
    logic             w_ha2_s;
    logic             w_ha2_c;
    logic             w_fa_c;
    logic [WIDTH-1:0] w_psum_next;

    // Full adder on the current LSBs: two half-adder stages, carries ORed.
    assign w_ha1_s     = r_a[0] ^ r_b[0];
    assign w_ha1_c     = r_a[0] & r_b[0];
    assign w_ha2_s     = w_ha1_s ^ r_carry;
    assign w_ha2_c     = w_ha1_s & r_carry;
    assign w_fa_c      = w_ha1_c | w_ha2_c;

    // Result bit enters at the MSB so that after WIDTH shifts bit 0 is at the LSB.
    assign w_psum_next = {w_ha2_s, r_psum[WIDTH-1:1]};
    assign w_last      = (r_cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand/carry/counter datapath plus the committed result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_psum  <= w_psum_next;
                    r_carry <= w_fa_c;
                    r_cnt   <= r_cnt + CW'(1);
                    // On the MSB cycle r_carry is the carry into the MSB, so the
                    // result is committed on this (DONE-entry) edge directly.
                    if (w_last) begin
                        r_sum  <= w_psum_next;
                        r_cout <= w_fa_c;
                        r_ovf  <= r_carry ^ w_fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder against
// an arithmetic reference model (acceptance time + integer addition).
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An operation accepted at edge number acc keeps the block busy through
    // edge acc+W, shows done after edge acc+W, and frees it at edge acc+W+1.
    int           e = 0;
    int           acc = 0;
    bit           active = 1'b0;
    int           ndone = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] p_sum;
    logic         p_cout;
    logic         p_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
            e      = 0;
        end else begin
            e = e + 1;
            if (active && e == acc + W) begin
                m_sum  = p_sum;
                m_cout = p_cout;
                m_ovf  = p_ovf;
                ndone++;
            end
            if (active && e == acc + W + 1) begin
                active = 1'b0;
            end else if (!active && start) begin
                longint full;
                longint sv;
                full   = longint'(a) + longint'(b) + longint'(cin);
                sv     = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
                p_sum  = full[W-1:0];
                p_cout = full[W];
                p_ovf  = (sv > (2 ** (W - 1)) - 1) || (sv < -(2 ** (W - 1)));
                acc    = e;
                active = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("busy", busy, active);
            chk("done", done, active && (e == acc + W));
            chk("sum",  sum,  m_sum);
            chk("cout", cout, m_cout);
            chk("ovf",  ovf,  m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic [W-1:0] es, input logic ec, input logic eo, input string nm);
        int n;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk({nm, "_latency"}, n, W + 1);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, cout, ec);
        chk({nm, "_ovf"}, ovf, eo);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int target;
        int cyc;

        #2 rst = 1'b1;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout_ovf", {cout, ovf}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Directed arithmetic cases with hand-computed results.
        do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ucarry1");
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "ucarry2");
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "sovf1");
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "sovf2");

        // Busy rejection: second request held high through SHIFT and DONE.
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'hAA; b = 8'h55;
        wait_done(n);
        chk("rej_latency", n, W + 1);
        chk("rej_sum", sum, 8'h46);
        @(negedge clk);
        chk("rej_idle_after_done", busy, 0);
        @(negedge clk);
        chk("rej_second_accept", busy, 1);
        start = 1'b0;
        wait_done(n);
        chk("rej2_latency", n, W + 1);
        chk("rej2_sum", sum, 8'hFF);
        chk("rej2_cout_ovf", {cout, ovf}, 0);
        @(negedge clk);

        // Reset in the middle of an operation.
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "pre_rst");
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_done", done, 0);
        chk("rst_async_sum", sum, 0);
        chk("rst_async_cout_ovf", {cout, ovf}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_no_partial_sum", sum, 0);
        do_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, "post_rst");

        // 1000 random back-to-back operations; start held high throughout.
        target = ndone + 1000;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        while (ndone < target && cyc < 20000) begin
            a   = W'($urandom_range(2 ** W - 1));
            b   = W'($urandom_range(2 ** W - 1));
            cin = 1'($urandom_range(1));
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("rand_ops_completed", ndone, target);
        repeat (W + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A; sampled on the accepting edge only.
REQ-006 SHALL have port b  input  WIDTH  operand B; sampled on the accepting edge only.
REQ-007 SHALL have port cin  input  1  carry-in; sampled on the accepting edge only.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-010 SHALL have port sum  output  WIDTH  registered result A+B+cin modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  registered carry-out of the MSB.
REQ-012 SHALL have port ovf  output  1  registered two's-complement overflow (carry into MSB XOR carry out of MSB).
REQ-013 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 In IDLE with start=1 at a rising edge, SHALL load a, b into operand shift registers, cin into the carry flop, clear the bit counter, and enter SHIFT.
REQ-016 In IDLE with start=0, SHALL remain in IDLE with all registers unchanged.
REQ-017 Each SHIFT cycle SHALL add the operand LSBs plus the carry flop with a full adder built from two half-adder stages plus an OR of their carries.
REQ-018 Each SHIFT cycle SHALL shift the result bit into the MSB of an internal partial-sum register (right shift), shift both operand registers right by one, update the carry flop, and increment the counter.
REQ-019 On the SHIFT cycle processing bit WIDTH-1, SHALL capture the carry flop value (carry into MSB) for overflow computation.
REQ-020 After exactly WIDTH SHIFT cycles, SHALL enter DONE.
REQ-021 On the DONE-entry edge, SHALL copy the partial sum to sum, the final carry to cout, and carry-into-MSB XOR cout to ovf.
REQ-022 done SHALL be 1 during the single DONE cycle and 0 in all other states.
REQ-023 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-024 Latency SHALL be fixed: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH; next start can be accepted at edge k+WIDTH+2.
REQ-025 start SHALL be ignored while busy=1, including during DONE; operand changes while busy SHALL not affect the operation in progress.
REQ-026 sum, cout, ovf SHALL hold their last committed values until the next DONE entry, remaining stable throughout a following operation.
REQ-027 Counter width SHALL be ceil(log2(WIDTH+1)) bits; no wrap-around within one operation.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear the carry flop, counter and shift registers.
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse, and no partial result SHALL reach sum.
REQ-030 After rst deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification (WIDTH=8)
REQ-031 Zero case: a=0x00, b=0x00, cin=0, start pulse -> busy high 9 cycles, done pulse 9 cycles after the accepting edge, sum=0x00, cout=0, ovf=0.
REQ-032 Unsigned carry: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
REQ-033 Signed overflow: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-034 Busy rejection: start with a=0x12, b=0x34, then start with a=0xAA, b=0x55 held high through SHIFT and DONE -> one done pulse, sum=0x46, second request not accepted until IDLE.
REQ-035 Reset mid-operation: commit 0x7F+0x01 (sum=0x80), start 0x0F+0x01, assert rst after 4 SHIFT cycles -> outputs all 0 asynchronously, no done pulse; a new 0x03+0x04 operation after release -> sum=0x07.
REQ-036 Random check: 1000 random a, b, cin, back-to-back -> each sum/cout matches {cout,sum}=a+b+cin and ovf matches the signed-overflow reference.
